// File: rtl/done_flag_arbiter.sv
// rtl/done_flag_arbiter.sv - round-robin done-flag writer and clear sweeper for SRAM port 2
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   clear_start       one-cycle pulse requesting a zero sweep of every entry
//   clear_busy        high while the sweep is writing
//   clear_done        one-cycle pulse alongside the last sweep write
//   req               per-unit write request, held until ack
//   req_addr/req_data packed per-unit address/status byte (unit i at slice i)
//   ack               one-hot pulse in the cycle the unit's write is on the bus
//   sram_*            port-2 SRAM strobes, registered; sram_clken tied high
module done_flag_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 512   // must equal 2**ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [ADDR_W-1:0]         sram_address,
  output logic                      sram_chipselect,
  output logic                      sram_write,
  output logic [DATA_W-1:0]         sram_writedata,
  output logic                      sram_clken
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PTR_W-1:0]    ptr, ptr_next;
  logic [PTR_W-1:0]    winner;
  logic                found;
  logic [ADDR_W-1:0]   cnt, cnt_next;

  logic [ADDR_W-1:0]   addr_q, addr_next;
  logic [DATA_W-1:0]   data_q, data_next;
  logic                strobe_q, strobe_next;
  logic [NUM_REQ-1:0]  ack_q, ack_next;
  logic                busy_q, busy_next;
  logic                done_q, done_next;

  logic [ADDR_W-1:0]   unit_addr [NUM_REQ];
  logic [DATA_W-1:0]   unit_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign unit_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign unit_data[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin search: first set request at or above ptr, wrapping to 0.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[PTR_W'(idx)]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    cnt_next    = cnt;
    addr_next   = '0;
    data_next   = '0;
    strobe_next = 1'b0;
    ack_next    = '0;
    busy_next   = 1'b0;
    done_next   = 1'b0;

    unique case (state)
      IDLE: begin
        if (clear_start) begin
          // Sweep wins over any request pending in the same cycle.
          state_next  = CLEAR;
          cnt_next    = '0;
          strobe_next = 1'b1;
          busy_next   = 1'b1;
          done_next   = (DEPTH == 1);
        end else if (found) begin
          state_next       = WRITE;
          addr_next        = unit_addr[winner];
          data_next        = unit_data[winner];
          strobe_next      = 1'b1;
          ack_next[winner] = 1'b1;
          ptr_next         = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
        end
      end

      WRITE: begin
        // Mandatory idle gap after every grant; clear_start here is dropped.
        state_next = IDLE;
      end

      CLEAR: begin
        // cnt is the address currently on the bus.
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next    = cnt + ADDR_W'(1);
          addr_next   = cnt + ADDR_W'(1);
          strobe_next = 1'b1;
          busy_next   = 1'b1;
          done_next   = (cnt + ADDR_W'(1) == ADDR_W'(DEPTH - 1));
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      cnt      <= cnt_next;
      addr_q   <= addr_next;
      data_q   <= data_next;
      strobe_q <= strobe_next;
      ack_q    <= ack_next;
      busy_q   <= busy_next;
      done_q   <= done_next;
    end
  end

  assign sram_address    = addr_q;
  assign sram_writedata  = data_q;
  assign sram_chipselect = strobe_q;
  assign sram_write      = strobe_q;
  assign ack             = ack_q;
  assign clear_busy      = busy_q;
  assign clear_done      = done_q;
  assign sram_clken      = 1'b1;

endmodule

// File: tb/tb_done_flag_arbiter.sv
// tb/tb_done_flag_arbiter.sv - directed scoreboard bench for done_flag_arbiter
module tb_done_flag_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;
  logic [3:0]  req;
  logic [35:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [8:0]  sram_address;
  logic        sram_chipselect;
  logic        sram_write;
  logic [7:0]  sram_writedata;
  logic        sram_clken;

  logic [8:0]  u_addr [4];
  logic [7:0]  u_data [4];
  logic [7:0]  mem [512];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
    logic [3:0] ack;
    logic       busy;
    logic       done;
  } exp_t;
  exp_t sb[$];

  assign req_addr = {u_addr[3], u_addr[2], u_addr[1], u_addr[0]};
  assign req_data = {u_data[3], u_data[2], u_data[1], u_data[0]};

  done_flag_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .clear_start     (clear_start),
    .clear_busy      (clear_busy),
    .clear_done      (clear_done),
    .req             (req),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .ack             (ack),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_writedata  (sram_writedata),
    .sram_clken      (sram_clken)
  );

  always #5 clk = ~clk;

  // Port-2 side of the SRAM, so sweep results can be read back.
  always @(posedge clk) begin
    if (sram_chipselect && sram_write) mem[sram_address] <= sram_writedata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] a, input logic [7:0] d, input logic [3:0] k,
                      input logic b, input logic dn);
    exp_t e;
    e.addr = a; e.data = d; e.ack = k; e.busy = b; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) push(9'(i), 8'h00, 4'b0000, 1'b1, i == 511);
  endtask

  task automatic wait_ack(input string tag, input logic [3:0] exp, input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (ack == 4'b0000 && cyc < max_cyc);
    check(tag, 32'(ack), 32'(exp));
  endtask

  // Scoreboard monitor: every write on the bus must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sram_write) begin
      check("sb_not_empty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_addr", 32'(sram_address), 32'(e.addr));
        check("wr_data", 32'(sram_writedata), 32'(e.data));
        check("wr_ack", 32'(ack), 32'(e.ack));
        check("wr_cs", 32'(sram_chipselect), 32'd1);
        check("wr_busy", 32'(clear_busy), 32'(e.busy));
        check("wr_done", 32'(clear_done), 32'(e.done));
      end
    end else begin
      check("idle_quiet", {ack, sram_chipselect, clear_done}, 32'd0);
    end
  end

  initial begin
    int cyc;
    int cnt;
    reset = 1'b1;
    clear_start = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      u_addr[i] = '0;
      u_data[i] = '0;
    end
    step();
    step();
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_addr", 32'(sram_address), 32'd0);
    check("rst_strobes", {sram_chipselect, sram_write}, 32'd0);
    check("rst_wdata", 32'(sram_writedata), 32'd0);
    check("clken", 32'(sram_clken), 32'd1);
    reset = 1'b0;
    step();

    // Single uncontended request: one-cycle latency, one-cycle strobe.
    u_addr[0] = 9'h05A; u_data[0] = 8'h01; req = 4'b0001;
    push(9'h05A, 8'h01, 4'b0001, 1'b0, 1'b0);
    step();
    check("t1_ack", 32'(ack), 32'h1);
    check("t1_addr", 32'(sram_address), 32'h05A);
    req = 4'b0000;
    step();
    check("t1_ack_drop", 32'(ack), 32'h0);
    check("t1_strobe_drop", 32'(sram_write), 32'h0);
    step();

    // All four requesting from a freshly reset pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      u_addr[i] = 9'(9'h010 + i);
      u_data[i] = 8'(8'hA0 + i);
      push(9'(9'h010 + i), 8'(8'hA0 + i), 4'(1 << i), 1'b0, 1'b0);
    end
    push(9'h1F0, 8'h55, 4'b0001, 1'b0, 1'b0);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack("t2_order", 4'(1 << (g % 4)), 6, cyc);
      check("t2_spacing", 32'(cyc), (g == 0) ? 32'd1 : 32'd2);
      if (g == 0) begin
        u_addr[0] = 9'h1F0; u_data[0] = 8'h55;
      end
      if (g == 4) req = 4'b0000;
    end
    step();

    // Fairness: pointer is 1; grant 2, then 0 (search 3 then wrap), then 2 again.
    u_addr[2] = 9'h0C2; u_data[2] = 8'h22; req = 4'b0100;
    push(9'h0C2, 8'h22, 4'b0100, 1'b0, 1'b0);
    wait_ack("t3_first", 4'b0100, 4, cyc);
    u_addr[2] = 9'h0C3; u_data[2] = 8'h23;
    u_addr[0] = 9'h0C0; u_data[0] = 8'h20;
    req = 4'b0101;
    push(9'h0C0, 8'h20, 4'b0001, 1'b0, 1'b0);
    push(9'h0C3, 8'h23, 4'b0100, 1'b0, 1'b0);
    wait_ack("t3_wrap", 4'b0001, 4, cyc);
    u_addr[0] = 9'h0C4; u_data[0] = 8'h24;
    wait_ack("t3_ptr1", 4'b0100, 4, cyc);
    // clear_start landing in the WRITE cycle is dropped.
    req = 4'b0000;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    check("t3_clr_drop", 32'(clear_busy), 32'd0);
    step();
    check("t3_clr_drop2", 32'(clear_busy), 32'd0);

    // Full sweep, with a stray clear_start mid-sweep that must be ignored.
    clear_start = 1'b1;
    push_sweep(512);
    step();
    clear_start = 1'b0;
    check("t4_busy_rise", 32'(clear_busy), 32'd1);
    cnt = 0;
    while (clear_busy && cnt < 600) begin
      cnt++;
      clear_start = (cnt == 200);
      step();
    end
    clear_start = 1'b0;
    check("t4_busy_len", 32'(cnt), 32'd512);
    check("t4_mem_05a", 32'(mem[9'h05A]), 32'd0);
    check("t4_mem_1f0", 32'(mem[9'h1F0]), 32'd0);
    check("t4_mem_0c3", 32'(mem[9'h0C3]), 32'd0);
    step();

    // Collision: sweep first, unit 3 acked the cycle after busy falls.
    u_addr[3] = 9'h133; u_data[3] = 8'h3C; req = 4'b1000;
    clear_start = 1'b1;
    push_sweep(512);
    push(9'h133, 8'h3C, 4'b1000, 1'b0, 1'b0);
    step();
    clear_start = 1'b0;
    check("t5_busy_rise", 32'(clear_busy), 32'd1);
    cnt = 0;
    while (clear_busy && cnt < 600) begin
      cnt++;
      step();
    end
    check("t5_busy_len", 32'(cnt), 32'd512);
    check("t5_no_ack_yet", 32'(ack), 32'd0);
    step();
    check("t5_ack3", 32'(ack), 32'b1000);
    req = 4'b0000;
    step();

    // Reset at sweep address 100 aborts; a new sweep restarts at 0.
    clear_start = 1'b1;
    push_sweep(101);
    step();
    clear_start = 1'b0;
    cnt = 0;
    while (sram_address != 9'd100 && cnt < 200) begin
      step();
      cnt++;
    end
    check("t6_at_100", 32'(sram_address), 32'd100);
    reset = 1'b1;
    step();
    check("t6_rst_busy", 32'(clear_busy), 32'd0);
    check("t6_rst_addr", 32'(sram_address), 32'd0);
    check("t6_rst_strobes", {ack, sram_chipselect, sram_write, clear_done}, 32'd0);
    check("t6_rst_wdata", 32'(sram_writedata), 32'd0);
    reset = 1'b0;
    step();
    check("t6_stays_idle", 32'(clear_busy), 32'd0);
    clear_start = 1'b1;
    push_sweep(512);
    step();
    clear_start = 1'b0;
    check("t6_restart_addr", 32'(sram_address), 32'd0);
    cnt = 0;
    while (clear_busy && cnt < 600) begin
      cnt++;
      step();
    end
    check("t6_busy_len", 32'(cnt), 32'd512);
    step();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
